clk_div_gen: RTL

Parametrised clock divider and clock-enable generator for the processor clock domain. It derives a slow square-wave clock `clkout` and a matching single-cycle enable `tick` from the board clock `clkin`, with a divisor that can be changed at run time. It also supports a single-step mode, so the processor can be advanced one clock period per button press during debug. It replaces the fixed divide-by-two toggler and sits between the board oscillator and the processor core and display logic.

---
 rtl/clk_div_gen_if.sv | 23 ++
 rtl/clk_div_gen.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/clk_div_gen_if.sv
// Control and output bundle of the clock divider / clock-enable generator.
// The master side drives mode, step and divisor loads; the slave side is the divider.
interface clk_div_gen_if #(
  parameter int WIDTH = 26
) ();
  logic             mode;
  logic             step;
  logic [WIDTH-1:0] div_in;
  logic             div_load;
  logic             clkout;
  logic             tick;
  logic             busy;

  modport master (
    output mode, step, div_in, div_load,
    input  clkout, tick, busy
  );

  modport slave (
    input  mode, step, div_in, div_load,
    output clkout, tick, busy
  );
endinterface

// File: rtl/clk_div_gen.sv
// Run-time programmable clock divider with free-run and single-step modes.
// clkout has a half-period of DIV clkin cycles; tick marks each clkout rising edge.
module clk_div_gen #(
  parameter int          WIDTH       = 26,
  parameter int unsigned DEFAULT_DIV = 10000000
) (
  input  logic           clkin,
  input  logic           rst,
  clk_div_gen_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] DEF_DIV = DEFAULT_DIV[WIDTH-1:0];

  // A divisor of zero has no meaningful period, so it behaves as one.
  function automatic logic [WIDTH-1:0] coerce_div(input logic [WIDTH-1:0] d);
    if (d == ZERO) begin
      coerce_div = ONE;
    end else begin
      coerce_div = d;
    end
  endfunction

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] div_act_r;
  logic [WIDTH-1:0] div_pend_r;
  logic             pend_v_r;
  logic             s1_r;
  logic             s2_r;
  logic             s3_r;
  logic             clkout_r;
  logic             tick_r;

  logic             step_edge_s;
  logic             tc_s;
  logic             reload_s;
  logic [WIDTH-1:0] div_in_c_s;

  assign step_edge_s = s2_r & ~s3_r;
  assign tc_s        = (state_r != IDLE) && (count_r == (div_act_r - ONE));
  assign div_in_c_s  = coerce_div(bus.div_in);
  assign reload_s    = (tc_s || (state_r == IDLE)) && (bus.div_load || pend_v_r);

  assign bus.clkout = clkout_r;
  assign bus.tick   = tick_r;
  assign bus.busy   = (state_r != IDLE);

  // Next-state decode; a period is only abandoned on the falling-edge terminal count.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!bus.mode) begin
          state_s = RUN;
        end else if (step_edge_s) begin
          state_s = STEP;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (tc_s && clkout_r && bus.mode) begin
          state_s = IDLE;
        end else begin
          state_s = RUN;
        end
      end
      STEP: begin
        if (tc_s && clkout_r) begin
          state_s = IDLE;
        end else begin
          state_s = STEP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clkin) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Step synchroniser plus half-period counter and output waveform.
  always_ff @(posedge clkin) begin
    if (rst) begin
      s1_r     <= 1'b0;
      s2_r     <= 1'b0;
      s3_r     <= 1'b0;
      count_r  <= ZERO;
      clkout_r <= 1'b0;
      tick_r   <= 1'b0;
    end else begin
      s1_r <= bus.step;
      s2_r <= s1_r;
      s3_r <= s2_r;
      if (state_r == IDLE) begin
        count_r  <= ZERO;
        clkout_r <= 1'b0;
        tick_r   <= 1'b0;
      end else if (tc_s) begin
        count_r  <= ZERO;
        clkout_r <= ~clkout_r;
        tick_r   <= ~clkout_r;
      end else begin
        count_r  <= count_r + ONE;
        tick_r   <= 1'b0;
      end
    end
  end

  // Divisor staging: a load waits for a half-period boundary (or IDLE) before it is applied.
  always_ff @(posedge clkin) begin
    if (rst) begin
      div_act_r  <= DEF_DIV;
      div_pend_r <= DEF_DIV;
      pend_v_r   <= 1'b0;
    end else begin
      if (bus.div_load) begin
        div_pend_r <= div_in_c_s;
      end else begin
        div_pend_r <= div_pend_r;
      end
      if (reload_s) begin
        div_act_r <= bus.div_load ? div_in_c_s : div_pend_r;
        pend_v_r  <= 1'b0;
      end else if (bus.div_load) begin
        div_act_r <= div_act_r;
        pend_v_r  <= 1'b1;
      end else begin
        div_act_r <= div_act_r;
        pend_v_r  <= pend_v_r;
      end
    end
  end

endmodule
